// File: rtl/pa_pkg.sv
// Shared types and default sizing for the product accumulator.
package pa_pkg;

  localparam int N_TERMS_DEF = 4;
  localparam int ACC_W_DEF   = 10;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } pa_state_t;

endpackage

// File: rtl/sat_add.sv
// Saturating adder: ACC_W-bit accumulator plus an 8-bit unsigned term,
// clamped to the all-ones value with an overflow indication.
module sat_add
  import pa_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [7:0]       b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] raw;

  assign raw = {1'b0, a} + {{(ACC_W-7){1'b0}}, b};
  assign ovf = raw[ACC_W];
  assign sum = ovf ? '1 : raw[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned 8-bit products into a saturating accumulator and
// presents each completed sum with a valid/ready handshake.
module product_accumulator
  import pa_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_prod,
  output logic             in_ready,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic [7:0]       out_cnt
);

  localparam logic [7:0] LAST_TERM = 8'(N_TERMS - 1);

  pa_state_t        state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [7:0]       term_cnt, term_cnt_next;
  logic             sat, sat_next;
  logic [7:0]       res_cnt, res_cnt_next;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (in_prod),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ACC;
      acc      <= '0;
      term_cnt <= '0;
      sat      <= 1'b0;
      res_cnt  <= '0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      term_cnt <= term_cnt_next;
      sat      <= sat_next;
      res_cnt  <= res_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    acc_next      = acc;
    term_cnt_next = term_cnt;
    sat_next      = sat;
    res_cnt_next  = res_cnt;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = 1'b1;
        // clear wins over a same-cycle beat
        if (clear) begin
          acc_next      = '0;
          term_cnt_next = '0;
          sat_next      = 1'b0;
        end else if (in_valid) begin
          acc_next      = add_sum;
          sat_next      = sat | add_ovf;
          term_cnt_next = term_cnt + 8'd1;
          if (term_cnt == LAST_TERM) state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next    = ST_ACC;
          acc_next      = '0;
          term_cnt_next = '0;
          sat_next      = 1'b0;
          res_cnt_next  = res_cnt + 8'd1;
        end
      end
      default: state_next = ST_ACC;
    endcase
  end

  // Result outputs come straight from the accumulator registers.
  assign out_sum = acc;
  assign out_sat = sat;
  assign out_cnt = res_cnt;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: two accumulators (ACC_W=10 and ACC_W=9) share stimulus.
module tb_product_accumulator;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, clear, out_ready;
  logic [7:0] in_prod;
  logic       in_ready_a, out_valid_a, out_sat_a;
  logic [9:0] out_sum_a;
  logic [7:0] out_cnt_a;
  logic       in_ready_b, out_valid_b, out_sat_b;
  logic [8:0] out_sum_b;
  logic [7:0] out_cnt_b;

  int total = 0;
  int bad   = 0;

  product_accumulator #(.N_TERMS(N), .ACC_W(10)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_prod(in_prod),
    .in_ready(in_ready_a), .clear(clear), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_sat(out_sat_a),
    .out_cnt(out_cnt_a)
  );

  product_accumulator #(.N_TERMS(N), .ACC_W(9)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_prod(in_prod),
    .in_ready(in_ready_b), .clear(clear), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_sat(out_sat_b),
    .out_cnt(out_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  typedef struct {
    int s10;
    bit t10;
    int s9;
    bit t9;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   terms[$];
  bit   collecting = 1'b1;
  int   delivered  = 0;

  // Reference: a group's result is the clamped plain sum of its terms.
  always @(posedge clk) begin
    if (rst) begin
      collecting = 1'b1;
      terms.delete();
      sb.delete();
      delivered = 0;
    end else if (collecting) begin
      if (clear) terms.delete();
      else if (in_valid) begin
        terms.push_back(int'(in_prod));
        if (terms.size() == N) begin
          int raw;
          exp_t e;
          raw = 0;
          foreach (terms[i]) raw += terms[i];
          e.s10 = (raw > 1023) ? 1023 : raw;
          e.t10 = raw > 1023;
          e.s9  = (raw > 511) ? 511 : raw;
          e.t9  = raw > 511;
          e.cnt = delivered % 256;
          sb.push_back(e);
          terms.delete();
          collecting = 1'b0;
        end
      end
    end else if (out_ready) begin
      collecting = 1'b1;
      delivered++;
    end
  end

  always @(negedge clk) begin
    check("in_ready_a", 32'(in_ready_a), 32'(collecting));
    check("out_valid_a", 32'(out_valid_a), 32'(!collecting));
    check("in_ready_b", 32'(in_ready_b), 32'(collecting));
    check("out_valid_b", 32'(out_valid_b), 32'(!collecting));
    if (out_valid_a === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(out_valid_a), 32'd0);
      end else begin
        check("sum10", 32'(out_sum_a), 32'(sb[0].s10));
        check("sat10", 32'(out_sat_a), 32'(sb[0].t10));
        check("sum9", 32'(out_sum_b), 32'(sb[0].s9));
        check("sat9", 32'(out_sat_b), 32'(sb[0].t9));
        check("cnt_a", 32'(out_cnt_a), 32'(sb[0].cnt));
        check("cnt_b", 32'(out_cnt_b), 32'(sb[0].cnt));
        if (out_ready === 1'b1) void'(sb.pop_front());
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] p, input bit c, input bit r, input bit rs);
    in_valid  = v;
    in_prod   = p;
    clear     = c;
    out_ready = r;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; clear = 1'b0; out_ready = 1'b0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("rst_in_ready", 32'(in_ready_a), 32'd1);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_out_sum", 32'(out_sum_a), 32'd0);
    check("rst_out_sat", 32'(out_sat_a), 32'd0);
    check("rst_out_cnt", 32'(out_cnt_a), 32'd0);

    repeat (4) step(1, 8'd225, 0, 0, 0);
    check("r31_valid", 32'(out_valid_a), 32'd1);
    check("r31_sum", 32'(out_sum_a), 32'd900);
    check("r31_sat", 32'(out_sat_a), 32'd0);
    check("r32_sum9", 32'(out_sum_b), 32'd511);
    check("r32_sat9", 32'(out_sat_b), 32'd1);

    for (int i = 0; i < 5; i++) begin
      step(1, 8'd99, (i == 2), 0, 0);
      check("r33_stable_sum", 32'(out_sum_a), 32'd900);
      check("r33_in_ready", 32'(in_ready_a), 32'd0);
    end
    step(1, 8'd99, 0, 1, 0);
    check("r33_cnt", 32'(out_cnt_a), 32'd1);
    check("r33_released", 32'(out_valid_a), 32'd0);

    repeat (4) step(1, 8'd1, 0, 0, 0);
    check("r32_sum_small", 32'(out_sum_b), 32'd4);
    check("r32_sat_small", 32'(out_sat_b), 32'd0);
    step(0, 0, 0, 1, 0);

    repeat (2) step(1, 8'd50, 0, 0, 0);
    step(1, 8'd77, 1, 0, 0);
    repeat (4) step(1, 8'd10, 0, 0, 0);
    check("r34_valid", 32'(out_valid_a), 32'd1);
    check("r34_sum", 32'(out_sum_a), 32'd40);
    step(0, 0, 0, 1, 0);

    repeat (4) step(1, 8'd225, 0, 0, 0);
    check("r35_pre_sum", 32'(out_sum_a), 32'd900);
    step(1, 8'd5, 1, 1, 1);
    check("r35_valid", 32'(out_valid_a), 32'd0);
    check("r35_sum", 32'(out_sum_a), 32'd0);
    check("r35_cnt", 32'(out_cnt_a), 32'd0);
    check("r35_in_ready", 32'(in_ready_a), 32'd1);

    for (int i = 0; i < 800; i++) begin
      logic [7:0] p;
      p = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
      step(($urandom % 10) < 7, p, ($urandom % 20) == 0,
           ($urandom % 2) == 1, ($urandom % 200) == 0);
    end

    step(0, 0, 0, 0, 1);
    cyc = 0;
    while (delivered < 257 && cyc < 4000) begin
      logic [7:0] p;
      p = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
      step(1, p, 0, 1, 0);
      cyc++;
    end
    check("r36_in_time", 32'(cyc < 4000), 32'd1);
    check("r36_cnt", 32'(out_cnt_a), 32'd1);

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
